// File: rtl/clk_seq_pkg.sv
// Shared types and select widths for the clock-select sequencer and the clock controller.
package clk_seq_pkg;

  localparam int MASTER_SEL_W = 1;
  localparam int DESIGN_SEL_W = 3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ASSERT,
    ST_SWITCH,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/clk_seq_timer.sv
// Loadable down-counter; 'expired' marks the last cycle of a loaded interval.
module clk_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (load)
      cnt <= value;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  // Loading N gives exactly N cycles before the owner sees expired acted upon.
  assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/clk_select_sequencer.sv
// Sequences clock-select changes: reset hold, select switch, settle, release.
// Optional: define CLK_SEQ_SKIP_SAME_EN to complete same-config requests without a reset pulse.
module clk_select_sequencer
  import clk_seq_pkg::*;
#(
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [MASTER_SEL_W-1:0] REQ_MASTER_SEL,
  input  logic [DESIGN_SEL_W-1:0] REQ_DESIGN_SEL,
  output logic [MASTER_SEL_W-1:0] MASTER_CLK_SELECT,
  output logic [DESIGN_SEL_W-1:0] DESIGN_CLK_SELECT,
  output logic                    PORESETn,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [CNT_W-1:0]        SWITCH_COUNT
);

  if (HOLD_CYCLES < 1 || SETTLE_CYCLES < 1 ||
      (HOLD_CYCLES >> CNT_W) != 0 || (SETTLE_CYCLES >> CNT_W) != 0) begin : g_param_chk
    $error("clk_select_sequencer: HOLD_CYCLES/SETTLE_CYCLES must be >= 1 and fit in CNT_W");
  end

  state_t                  state;
  logic [MASTER_SEL_W-1:0] hold_master;
  logic [DESIGN_SEL_W-1:0] hold_design;
  logic                    accept;
  logic                    skip;
  logic                    timer_load;
  logic [CNT_W-1:0]        timer_value;
  logic                    expired;

  assign accept = REQ_VALID && REQ_READY && (state == ST_IDLE);

`ifdef CLK_SEQ_SKIP_SAME_EN
  assign skip = (REQ_MASTER_SEL == MASTER_CLK_SELECT) && (REQ_DESIGN_SEL == DESIGN_CLK_SELECT);
`else
  assign skip = 1'b0;
`endif

  // One timer serves INIT/SETTLE (loaded on reset and leaving SWITCH) and ASSERT (on accept).
  assign timer_load  = RESET || (accept && !skip) || (state == ST_SWITCH);
  assign timer_value = (!RESET && state == ST_IDLE) ? CNT_W'(HOLD_CYCLES) : CNT_W'(SETTLE_CYCLES);

  clk_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK     (CLK),
    .load    (timer_load),
    .value   (timer_value),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state             <= ST_INIT;
      PORESETn          <= 1'b0;
      MASTER_CLK_SELECT <= '0;
      DESIGN_CLK_SELECT <= '0;
      REQ_READY         <= 1'b0;
      BUSY              <= 1'b1;
      DONE              <= 1'b0;
      SWITCH_COUNT      <= '0;
      hold_master       <= '0;
      hold_design       <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_INIT: begin
          if (expired) begin
            state     <= ST_IDLE;
            PORESETn  <= 1'b1;
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept && skip) begin
            DONE <= 1'b1;
          end else if (accept) begin
            state       <= ST_ASSERT;
            hold_master <= REQ_MASTER_SEL;
            hold_design <= REQ_DESIGN_SEL;
            PORESETn    <= 1'b0;
            REQ_READY   <= 1'b0;
            BUSY        <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // Selects move only here, deep inside the reset window.
          if (expired) begin
            state             <= ST_SWITCH;
            MASTER_CLK_SELECT <= hold_master;
            DESIGN_CLK_SELECT <= hold_design;
            SWITCH_COUNT      <= SWITCH_COUNT + CNT_W'(1);
          end
        end
        ST_SWITCH: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (expired) begin
            state     <= ST_IDLE;
            PORESETn  <= 1'b1;
            DONE      <= 1'b1;
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_select_sequencer.sv
// Directed bench for clk_select_sequencer: reset/INIT, table of switches, back-to-back,
// same-config, reset mid-SETTLE and count wrap, with cycle-exact expected outputs.
module tb_clk_select_sequencer;

  localparam int HOLD   = 4;
  localparam int SETTLE = 8;
  localparam int K_SEL  = HOLD + 1;
  localparam int K_DONE = HOLD + SETTLE + 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_MASTER_SEL = 1'b0;
  logic [2:0] REQ_DESIGN_SEL = 3'd0;
  logic       MASTER_CLK_SELECT;
  logic [2:0] DESIGN_CLK_SELECT;
  logic       PORESETn;
  logic       BUSY;
  logic       DONE;
  logic [7:0] SWITCH_COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  // model of the current configuration and of the request in flight
  logic       old_m = 1'b0, new_m = 1'b0;
  logic [2:0] old_d = 3'd0, new_d = 3'd0;
  logic [7:0] old_cnt = 8'd0;

  typedef struct {
    logic       m;
    logic [2:0] d;
    logic [7:0] exp_cnt;
    string      name;
  } vec_t;
  vec_t tbl[6];

  clk_select_sequencer #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .REQ_VALID         (REQ_VALID),
    .REQ_READY         (REQ_READY),
    .REQ_MASTER_SEL    (REQ_MASTER_SEL),
    .REQ_DESIGN_SEL    (REQ_DESIGN_SEL),
    .MASTER_CLK_SELECT (MASTER_CLK_SELECT),
    .DESIGN_CLK_SELECT (DESIGN_CLK_SELECT),
    .PORESETn          (PORESETn),
    .BUSY              (BUSY),
    .DONE              (DONE),
    .SWITCH_COUNT      (SWITCH_COUNT)
  );

  always #5 CLK = ~CLK;

  // fields: {PORESETn, REQ_READY, DONE, BUSY, MASTER, DESIGN, COUNT}
  function automatic logic [15:0] act_vec();
    return {PORESETn, REQ_READY, DONE, BUSY, MASTER_CLK_SELECT, DESIGN_CLK_SELECT, SWITCH_COUNT};
  endfunction

  function automatic logic [15:0] exp_seq(input int k);
    logic sw, fin;
    sw  = (k >= K_SEL);
    fin = (k >= K_DONE);
    return {fin, fin, (k == K_DONE), !fin, sw ? new_m : old_m, sw ? new_d : old_d,
            sw ? old_cnt + 8'd1 : old_cnt};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input int k, input logic [15:0] a, input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got{por,rdy,done,busy,m,d,cnt}=%h want=%h", nm, k, a, e);
    end
  endtask

  // called while RESET is high after at least one edge; then releases it and walks INIT
  task automatic reset_and_init(input string nm);
    check({nm, "_reset"}, 0, act_vec(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0});
    RESET = 1'b0;
    for (int j = 1; j <= SETTLE; j++) begin
      step();
      if (j < SETTLE)
        check({nm, "_init"}, j, act_vec(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0});
      else
        check({nm, "_init_done"}, j, act_vec(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0});
    end
    old_m = 1'b0; old_d = 3'd0; old_cnt = 8'd0;
  endtask

  // Issue a request at the current (IDLE) cycle and check cycles T+1..T+stop_k.
  // chain keeps REQ_VALID high (with junk codes) so the next call is accepted in the DONE cycle.
  task automatic run_seq(input logic m, input logic [2:0] d, input string nm,
                         input int stop_k, input bit chain);
    new_m = m; new_d = d;
    REQ_VALID = 1'b1; REQ_MASTER_SEL = m; REQ_DESIGN_SEL = d;
    step();
    if (chain) begin
      REQ_MASTER_SEL = ~m; REQ_DESIGN_SEL = d ^ 3'b011;
    end else begin
      REQ_VALID = 1'b0;
    end
    for (int k = 1; k <= stop_k; k++) begin
      if (k > 1) step();
      check(nm, k, act_vec(), exp_seq(k));
    end
    if (stop_k == K_DONE) begin
      old_m = new_m; old_d = new_d; old_cnt = old_cnt + 8'd1;
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'd5, 8'd1, "sw_1_5"};
    tbl[1] = '{1'b0, 3'd2, 8'd2, "sw_0_2"};
    tbl[2] = '{1'b1, 3'd7, 8'd3, "sw_1_7"};
    tbl[3] = '{1'b0, 3'd0, 8'd4, "sw_0_0"};
    tbl[4] = '{1'b1, 3'd3, 8'd5, "sw_1_3"};
    tbl[5] = '{1'b0, 3'd6, 8'd6, "sw_0_6"};

    // reset held for 3 edges, then INIT must last SETTLE cycles
    repeat (3) step();
    reset_and_init("por");

    for (int i = 0; i < 6; i++) begin
      run_seq(tbl[i].m, tbl[i].d, tbl[i].name, K_DONE, 1'b0);
      check({tbl[i].name, "_count"}, K_DONE, {8'd0, SWITCH_COUNT}, {8'd0, tbl[i].exp_cnt});
    end

    // back-to-back with REQ_VALID held: second accept in the DONE cycle, junk codes ignored
    run_seq(1'b1, 3'd5, "b2b_first", K_DONE, 1'b1);
    run_seq(1'b0, 3'd2, "b2b_second", K_DONE, 1'b0);
    check("b2b_count", 0, {8'd0, SWITCH_COUNT}, {8'd0, 8'd8});

    // same-configuration request (current is 0/2)
`ifdef CLK_SEQ_SKIP_SAME_EN
    REQ_VALID = 1'b1; REQ_MASTER_SEL = 1'b0; REQ_DESIGN_SEL = 3'd2;
    step();
    REQ_VALID = 1'b0;
    check("same_done", 1, act_vec(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, old_cnt});
    step();
    check("same_after", 2, act_vec(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, old_cnt});
`else
    run_seq(1'b0, 3'd2, "same_full", K_DONE, 1'b0);
    check("same_count", 0, {8'd0, SWITCH_COUNT}, {8'd0, 8'd9});
`endif

    // reset during SETTLE: request dropped, back to reset values, no DONE
    run_seq(1'b1, 3'd5, "mid_pre", 9, 1'b0);
    RESET = 1'b1;
    step();
    reset_and_init("mid");

    // 256 switches from count 0: 255 then wrap to 0
    for (int i = 0; i < 256; i++) begin
      bit got;
      REQ_VALID = 1'b1;
      REQ_MASTER_SEL = i[0] ? 1'b0 : 1'b1;
      REQ_DESIGN_SEL = i[0] ? 3'd2 : 3'd5;
      step();
      REQ_VALID = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        step();
        if (DONE) got = 1'b1;
      end
      check("wrap_done_seen", i, {15'd0, got}, 16'd1);
      if (!got) break;
      if (i == 254) check("wrap_255", i, {8'd0, SWITCH_COUNT}, 16'd255);
    end
    check("wrap_0", 256, {8'd0, SWITCH_COUNT}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
